bp_me_cce_req_scheduler: RTL and testbench

- Shares one address-to-CCE-ID mapper between num_req_p request sources (LCE/IO side).
- Round-robin arbitrates incoming requests and drives the winning paddr into the shared mapper.
- Registers the returned CCE ID and forwards the request to the network only when that destination CCE has a free credit.
- Sits between request sources and the CCE-bound wormhole injection port.

---
 rtl/bp_me_cce_req_scheduler.sv | 153 +++++++++++++++
 tb/tb_bp_me_cce_req_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_req_scheduler.sv
// Round-robin request scheduler sharing one paddr->CCE-ID mapper, with per-CCE send credits.
// Latency: accept at N, out_v_o earliest at N+2; one request per 3 cycles at best.
// Backpressure: holds one request; blocks (head-of-line) on out_ready_i or zero credit for its CCE.
module bp_me_cce_req_scheduler #(
    parameter int num_req_p       = 4,
    parameter int paddr_width_p   = 40,
    parameter int payload_width_p = 64,
    parameter int cce_id_width_p  = 6,
    parameter int num_cce_p       = 4,
    parameter int credits_p       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    output logic [num_req_p-1:0]                   req_ready_o,
    input  logic [num_req_p*paddr_width_p-1:0]     req_paddr_i,
    input  logic [num_req_p*payload_width_p-1:0]   req_data_i,
    output logic [paddr_width_p-1:0]               mapper_paddr_o,
    input  logic [cce_id_width_p-1:0]              mapper_cce_id_i,
    output logic                                   out_v_o,
    input  logic                                   out_ready_i,
    output logic [cce_id_width_p-1:0]              out_cce_id_o,
    output logic [$clog2(num_req_p)-1:0]           out_src_id_o,
    output logic [paddr_width_p-1:0]               out_paddr_o,
    output logic [payload_width_p-1:0]             out_data_o,
    input  logic                                   credit_return_v_i,
    input  logic [cce_id_width_p-1:0]              credit_return_id_i,
    output logic                                   error_o
);

    localparam int src_w_lp = $clog2(num_req_p);
    localparam int cnt_w_lp = $clog2(credits_p + 1);
    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(credits_p);

    typedef enum logic [1:0] {e_ready, e_map, e_send} state_e;

    state_e                      state_r, state_n;
    logic [src_w_lp-1:0]         ptr_r, src_r, grant_idx;
    logic                        grant_v;
    logic [num_req_p-1:0]        grant_oh;
    logic [paddr_width_p-1:0]    paddr_r;
    logic [payload_width_p-1:0]  data_r;
    logic [cce_id_width_p-1:0]   cce_id_r;
    logic [cnt_w_lp-1:0]         credit_r [num_cce_p];
    logic [cnt_w_lp-1:0]         cur_credit;
    logic                        map_ok, ret_id_ok, ret_full_err, send, err_r;

    // Round-robin scan starting just past the last winner.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int off = 1; off <= num_req_p; off++) begin
            if (!grant_v && req_v_i[(int'(ptr_r) + off) % num_req_p]) begin
                grant_v   = 1'b1;
                grant_idx = src_w_lp'((int'(ptr_r) + off) % num_req_p);
            end
        end
        grant_oh = '0;
        if (grant_v)
            grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        cur_credit = '0;
        for (int i = 0; i < num_cce_p; i++)
            if (cce_id_r == cce_id_width_p'(i))
                cur_credit = credit_r[i];
    end

    assign map_ok    = mapper_cce_id_i < cce_id_width_p'(num_cce_p);
    assign ret_id_ok = credit_return_id_i < cce_id_width_p'(num_cce_p);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= e_ready;
        else
            state_r <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready: if (grant_v) state_n = e_map;
            e_map:   state_n = map_ok ? e_send : e_ready;
            e_send:  if (send) state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    // Outputs; reset gating guarantees no handshake during a reset cycle.
    always_comb begin
        req_ready_o = (state_r == e_ready && !reset_i) ? grant_oh : '0;
        out_v_o     = (state_r == e_send) && (cur_credit != '0) && !reset_i;
        send        = out_v_o && out_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r    <= src_w_lp'(num_req_p - 1);
            src_r    <= '0;
            paddr_r  <= '0;
            data_r   <= '0;
            cce_id_r <= '0;
        end else begin
            if (state_r == e_ready && grant_v) begin
                ptr_r   <= grant_idx;
                src_r   <= grant_idx;
                paddr_r <= req_paddr_i[grant_idx*paddr_width_p +: paddr_width_p];
                data_r  <= req_data_i[grant_idx*payload_width_p +: payload_width_p];
            end
            if (state_r == e_map)
                cce_id_r <= mapper_cce_id_i;
        end
    end

    // A return to an already-full counter is an error unless it cancels a send on that ID.
    always_comb begin
        ret_full_err = 1'b0;
        for (int i = 0; i < num_cce_p; i++)
            if (credit_return_v_i && credit_return_id_i == cce_id_width_p'(i)
                && !(send && cce_id_r == cce_id_width_p'(i)) && credit_r[i] == full_lp)
                ret_full_err = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_cce_p; i++)
                credit_r[i] <= full_lp;
            err_r <= 1'b0;
        end else begin
            for (int i = 0; i < num_cce_p; i++) begin
                if (credit_return_v_i && credit_return_id_i == cce_id_width_p'(i)) begin
                    if (!(send && cce_id_r == cce_id_width_p'(i)) && credit_r[i] != full_lp)
                        credit_r[i] <= credit_r[i] + 1'b1;
                end else if (send && cce_id_r == cce_id_width_p'(i)) begin
                    credit_r[i] <= credit_r[i] - 1'b1;
                end
            end
            if ((state_r == e_map && !map_ok) || (credit_return_v_i && !ret_id_ok) || ret_full_err)
                err_r <= 1'b1;
        end
    end

    assign mapper_paddr_o = paddr_r;
    assign out_cce_id_o   = cce_id_r;
    assign out_src_id_o   = src_r;
    assign out_paddr_o    = paddr_r;
    assign out_data_o     = data_r;
    assign error_o        = err_r;

endmodule

// File: tb/tb_bp_me_cce_req_scheduler.sv
// Randomized bench for bp_me_cce_req_scheduler against a transaction-level reference model.
module tb_bp_me_cce_req_scheduler;
    localparam int NR = 4, PW = 40, DW = 64, IW = 6, NC = 4, CR = 8;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [NR-1:0]        req_v_i, req_ready_o;
    logic [NR*PW-1:0]     req_paddr_i;
    logic [NR*DW-1:0]     req_data_i;
    logic [PW-1:0]        mapper_paddr_o;
    logic [IW-1:0]        mapper_cce_id_i;
    logic                 out_v_o, out_ready_i;
    logic [IW-1:0]        out_cce_id_o;
    logic [1:0]           out_src_id_o;
    logic [PW-1:0]        out_paddr_o;
    logic [DW-1:0]        out_data_o;
    logic                 credit_return_v_i;
    logic [IW-1:0]        credit_return_id_i;
    logic                 error_o;

    always #5 clk = ~clk;

    // Mapper: destination is the low address bits.
    assign mapper_cce_id_i = mapper_paddr_o[IW-1:0];

    bp_me_cce_req_scheduler dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_paddr_i(req_paddr_i), .req_data_i(req_data_i),
        .mapper_paddr_o(mapper_paddr_o), .mapper_cce_id_i(mapper_cce_id_i),
        .out_v_o(out_v_o), .out_ready_i(out_ready_i),
        .out_cce_id_o(out_cce_id_o), .out_src_id_o(out_src_id_o),
        .out_paddr_o(out_paddr_o), .out_data_o(out_data_o),
        .credit_return_v_i(credit_return_v_i), .credit_return_id_i(credit_return_id_i),
        .error_o(error_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one held request, cycles since it was accepted, credits, sticky error.
    bit              m_busy;
    int              m_age;
    int              m_ptr;
    int              m_src;
    int              m_id;
    logic [PW-1:0]   m_paddr;
    logic [DW-1:0]   m_data;
    int              m_cred [NC];
    bit              m_err;

    task automatic model_reset();
        m_busy  = 0;
        m_age   = 0;
        m_ptr   = NR - 1;
        m_paddr = '0;
        m_err   = 0;
        for (int i = 0; i < NC; i++) m_cred[i] = CR;
    endtask

    // mode 0: legal traffic, mode 1: illegal IDs and returns, mode 2: all traffic to CCE 1, rare returns
    task automatic cycle(input int mode, input bit rst);
        bit              exp_v, send, same;
        int              win, rid, r;
        logic [NR-1:0]   exp_rdy;
        logic [PW-1:0]   p;
        @(posedge clk);
        #1;
        reset_i = rst;
        exp_v   = !rst && m_busy && m_age >= 2 && m_cred[m_id] > 0;
        for (int i = 0; i < NR; i++) begin
            req_v_i[i] = ($urandom_range(0, 2) == 0);
            p = PW'({$urandom, $urandom});
            if (mode == 2)
                p[IW-1:0] = 6'd1;
            else if (mode == 1 && $urandom_range(0, 7) == 0)
                p[IW-1:0] = 6'($urandom_range(NC, 63));
            else
                p[IW-1:0] = 6'($urandom_range(0, NC - 1));
            req_paddr_i[i*PW +: PW] = p;
            req_data_i[i*DW +: DW]  = {$urandom, $urandom};
        end
        out_ready_i        = ($urandom_range(0, 3) != 0);
        credit_return_v_i  = 1'b0;
        credit_return_id_i = '0;
        r = $urandom_range(0, 19);
        if ((mode == 2) ? (r == 0) : (r < 6)) begin
            if (mode == 1) begin
                rid = $urandom_range(0, NC);
                credit_return_v_i  = 1'b1;
                credit_return_id_i = (rid == NC) ? 6'd7 : 6'(rid);
            end else begin
                rid = (exp_v && out_ready_i && r < 2) ? m_id : $urandom_range(0, NC - 1);
                if (m_cred[rid] < CR || (exp_v && out_ready_i && rid == m_id)) begin
                    credit_return_v_i  = 1'b1;
                    credit_return_id_i = 6'(rid);
                end
            end
        end

        @(negedge clk);
        win = -1;
        for (int off = 1; off <= NR; off++)
            if (win < 0 && req_v_i[(m_ptr + off) % NR]) win = (m_ptr + off) % NR;
        exp_rdy = '0;
        if (!rst && !m_busy && win >= 0) exp_rdy[win] = 1'b1;
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        check("out_v", 64'(out_v_o), 64'(exp_v));
        check("error", 64'(error_o), 64'(m_err));
        check("mapper_paddr", 64'(mapper_paddr_o), 64'(m_paddr));
        if (exp_v) begin
            check("out_cce_id", 64'(out_cce_id_o), 64'(m_id));
            check("out_src_id", 64'(out_src_id_o), 64'(m_src));
            check("out_paddr", 64'(out_paddr_o), 64'(m_paddr));
            check("out_data", out_data_o, m_data);
        end

        if (rst) begin
            model_reset();
            return;
        end
        send = exp_v && out_ready_i;
        same = 0;
        if (credit_return_v_i) begin
            rid = int'(credit_return_id_i);
            if (rid >= NC) m_err = 1;
            else if (send && rid == m_id) same = 1;
            else if (m_cred[rid] == CR) m_err = 1;
            else m_cred[rid]++;
        end
        if (send && !same) m_cred[m_id]--;
        if (!m_busy && win >= 0) begin
            m_busy  = 1;
            m_age   = 1;
            m_ptr   = win;
            m_src   = win;
            m_paddr = req_paddr_i[win*PW +: PW];
            m_data  = req_data_i[win*DW +: DW];
        end else if (m_busy && m_age == 1) begin
            m_id = int'(m_paddr[IW-1:0]);
            if (m_id >= NC) begin
                m_err  = 1;
                m_busy = 0;
            end else begin
                m_age = 2;
            end
        end else if (send) begin
            m_busy = 0;
        end
    endtask

    initial begin
        reset_i            = 1'b1;
        req_v_i            = '0;
        req_paddr_i        = '0;
        req_data_i         = '0;
        out_ready_i        = 1'b0;
        credit_return_v_i  = 1'b0;
        credit_return_id_i = '0;
        model_reset();
        cycle(0, 1);
        cycle(0, 1);
        for (int seg = 0; seg < 12; seg++) begin
            for (int c = 0; c < 300; c++)
                cycle(seg % 3, 0);
            cycle(seg % 3, 1);
        end
        for (int c = 0; c < 5; c++)
            cycle(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
